// File: rtl/niosii_system_sysid_checker_pkg.sv
// rtl/niosii_system_sysid_checker_pkg.sv - shared types and constants for the sysid checker
package niosii_system_sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        CMP   = 3'd5,
        HOLD  = 3'd6,
        FIN   = 3'd7
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int   TIMER_W = 16;

    // States in which a read command is pending or outstanding and the timeout applies.
    function automatic logic is_bus_state(input state_t s);
        return (s == RD_ID) || (s == WT_ID) || (s == RD_TS) || (s == WT_TS);
    endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_timer.sv
// rtl/niosii_system_sysid_checker_timer.sv - loadable saturating up-counter with terminal-count compare
module niosii_system_sysid_checker_timer
    import niosii_system_sysid_checker_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] terminal,
    output logic               tc
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - reads sysid ID and timestamp words, compares, retries, reports status
module niosii_system_sysid_checker
    import niosii_system_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1488912150,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned HOLDOFF_CYCLES     = 16,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    localparam logic [3:0]         MAX_RETRY_L = 4'(MAX_RETRIES);
    localparam logic [TIMER_W-1:0] TIMEOUT_L   = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLDOFF_CYCLES - 1);

    state_t      state, state_d;
    logic        auto_pending;
    logic        m_read_d, m_address_d, done_d, pass_d, timeout_err_d;
    logic [31:0] id_d, ts_d;
    logic [3:0]  retry_d;
    logic        timer_load, timer_tc, can_retry;

    niosii_system_sysid_checker_timer u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (timer_load),
        .terminal ((state == HOLD) ? HOLD_LAST : TIMEOUT_L),
        .tc       (timer_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
            m_read       <= 1'b0;
            m_address    <= ADDR_ID;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout_err  <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
            retry_count  <= '0;
        end else begin
            state        <= state_d;
            auto_pending <= 1'b0;
            m_read       <= m_read_d;
            m_address    <= m_address_d;
            done         <= done_d;
            pass         <= pass_d;
            timeout_err  <= timeout_err_d;
            id_value     <= id_d;
            ts_value     <= ts_d;
            retry_count  <= retry_d;
        end
    end

    assign can_retry = (retry_count < MAX_RETRY_L);

    always_comb begin
        state_d       = state;
        done_d        = done;
        pass_d        = pass;
        timeout_err_d = timeout_err;
        id_d          = id_value;
        ts_d          = ts_value;
        retry_d       = retry_count;
        case (state)
            IDLE: if (start || auto_pending) begin
                state_d       = RD_ID;
                done_d        = 1'b0;
                pass_d        = 1'b0;
                timeout_err_d = 1'b0;
                retry_d       = '0;
            end
            // A response in the acceptance cycle is captured and the wait state skipped.
            RD_ID: if (!m_waitrequest) begin
                if (m_readdatavalid) begin
                    id_d    = m_readdata;
                    state_d = RD_TS;
                end else begin
                    state_d = WT_ID;
                end
            end else if (timer_tc) begin
                state_d = HOLD;
            end
            WT_ID: if (m_readdatavalid) begin
                id_d    = m_readdata;
                state_d = RD_TS;
            end else if (timer_tc) begin
                state_d = HOLD;
            end
            RD_TS: if (!m_waitrequest) begin
                if (m_readdatavalid) begin
                    ts_d    = m_readdata;
                    state_d = CMP;
                end else begin
                    state_d = WT_TS;
                end
            end else if (timer_tc) begin
                state_d = HOLD;
            end
            WT_TS: if (m_readdatavalid) begin
                ts_d    = m_readdata;
                state_d = CMP;
            end else if (timer_tc) begin
                state_d = HOLD;
            end
            CMP: if ((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP)) begin
                state_d = FIN;
                pass_d  = 1'b1;
            end else if (can_retry) begin
                retry_d = retry_count + 4'd1;
                state_d = RD_ID;
            end else begin
                state_d = FIN;
            end
            HOLD: if (timer_tc) begin
                if (can_retry) begin
                    retry_d = retry_count + 4'd1;
                    state_d = RD_ID;
                end else begin
                    state_d       = FIN;
                    timeout_err_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FIN) begin
            done_d = 1'b1;
        end
        m_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
        m_address_d = ((state_d == RD_TS) || (state_d == WT_TS)) ? ADDR_TS : ADDR_ID;
        // The timer spans a whole read (command plus wait) and restarts for each holdoff.
        timer_load  = (state_d != state) &&
                      ((state_d == RD_ID) || (state_d == RD_TS) || (state_d == HOLD));
    end

    assign busy = (state != IDLE) && (state != FIN) &&
                  (is_bus_state(state) || (state == CMP) || (state == HOLD));

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - directed self-checking bench for the sysid checker
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1488912150;
    localparam int B_TIMEOUT = 10;
    localparam int HOLDOFF   = 16;

    logic clock = 1'b0;
    logic reset_n, start, sel;
    always #5 clock = ~clock;

    logic        a_m_address, a_m_read, a_busy, a_done, a_pass, a_tmo;
    logic [31:0] a_id, a_ts;
    logic [3:0]  a_retry;
    logic        b_m_address, b_m_read, b_busy, b_done, b_pass, b_tmo;
    logic [31:0] b_id, b_ts;
    logic [3:0]  b_retry;

    logic        s_wr = 1'b0, s_rdv = 1'b0, inject;
    logic [31:0] s_data = '0, inj_data;
    logic        m_waitrequest, m_readdatavalid;
    logic [31:0] m_readdata;
    assign m_waitrequest   = s_wr;
    assign m_readdatavalid = s_rdv | inject;
    assign m_readdata      = inject ? inj_data : s_data;

    niosii_system_sysid_checker dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .m_address(a_m_address), .m_read(a_m_read), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
        .busy(a_busy), .done(a_done), .pass(a_pass), .timeout_err(a_tmo),
        .id_value(a_id), .ts_value(a_ts), .retry_count(a_retry)
    );

    niosii_system_sysid_checker #(.TIMEOUT_CYCLES(B_TIMEOUT), .MAX_RETRIES(1)) dut_to (
        .clock(clock), .reset_n(reset_n), .start(start),
        .m_address(b_m_address), .m_read(b_m_read), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
        .busy(b_busy), .done(b_done), .pass(b_pass), .timeout_err(b_tmo),
        .id_value(b_id), .ts_value(b_ts), .retry_count(b_retry)
    );

    logic        o_m_read, o_m_address, o_busy, o_done, o_pass, o_tmo;
    logic [31:0] o_id, o_ts;
    logic [3:0]  o_retry;
    assign o_m_read    = sel ? b_m_read    : a_m_read;
    assign o_m_address = sel ? b_m_address : a_m_address;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_done      = sel ? b_done      : a_done;
    assign o_pass      = sel ? b_pass      : a_pass;
    assign o_tmo       = sel ? b_tmo       : a_tmo;
    assign o_id        = sel ? b_id        : a_id;
    assign o_ts        = sel ? b_ts        : a_ts;
    assign o_retry     = sel ? b_retry     : a_retry;

    // Slave: wait_n stall cycles per command, response resp_d cycles after acceptance.
    int wait_n, resp_d, ts_bad, base;
    logic respond;
    int st = 0, pend = 0, acc0 = 0;
    logic [31:0] p_data = '0, rdata;
    always @(posedge clock) begin
        #1;
        if (!reset_n) begin
            st = 0; pend = 0; s_wr = 1'b0; s_rdv = 1'b0;
        end else begin
            s_rdv = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin s_rdv = respond; s_data = p_data; end
            end
            s_wr = 1'b0;
            if (sel ? b_m_read : a_m_read) begin
                if (st < wait_n) begin
                    s_wr = 1'b1; st++;
                end else begin
                    st = 0;
                    if ((sel ? b_m_address : a_m_address) == 1'b0) begin
                        acc0++; rdata = EXP_ID;
                    end else begin
                        rdata = (acc0 - base - 1 < ts_bad) ? EXP_TS + 32'd1 : EXP_TS;
                    end
                    if (resp_d == 0) begin s_rdv = respond; s_data = rdata; end
                    else begin pend = resp_d; p_data = rdata; end
                end
            end
        end
    end

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    // Scenario expectations: n_exp from the timing model, lit_* hand-computed.
    int          t0 = 0, n_exp = 0, lit_done = 0, lit_retry = 0, fin_target = 0;
    logic        armed = 1'b0, lit_pass = 1'b0, lit_tmo = 1'b0;
    logic [31:0] lit_id = '0, lit_ts = '0;

    int n_cmp = 0, n_bad = 0, fin_count = 0, done_at = -1;
    logic p_read = 1'b0, p_wr = 1'b0, p_addr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        int cyc;
        cyc = edges - t0;
        if (!reset_n) begin
            chk("reset_ctl", 32'({o_m_read, o_m_address, o_busy, o_done, o_pass, o_tmo, o_retry}), 32'd0);
            chk("reset_id", o_id, 32'd0);
            chk("reset_ts", o_ts, 32'd0);
        end else if (armed && cyc >= 1 && cyc <= n_exp + 3) begin
            if (cyc == 1) done_at = -1;
            chk("busy", 32'(o_busy), 32'(cyc < n_exp));
            chk("done", 32'(o_done), 32'(cyc >= n_exp));
            if (o_m_read) chk("read_while_busy", 32'(o_busy), 32'd1);
            if (cyc >= 2 && p_read && p_wr) begin
                chk("stall_read", 32'(o_m_read), 32'd1);
                chk("stall_addr", 32'(o_m_address), 32'(p_addr));
            end
            if (o_done && done_at < 0) done_at = cyc;
            if (cyc == n_exp + 3) begin
                chk("done_cycle", done_at, lit_done);
                chk("pass", 32'(o_pass), 32'(lit_pass));
                chk("retry_count", 32'(o_retry), lit_retry);
                chk("timeout_err", 32'(o_tmo), 32'(lit_tmo));
                chk("id_value", o_id, lit_id);
                chk("ts_value", o_ts, lit_ts);
                fin_count++;
            end
        end
        p_read = o_m_read; p_wr = m_waitrequest; p_addr = o_m_address;
    end

    function automatic int model_ok(input int attempts, input int w, input int d);
        return 1 + attempts * (2 * (1 + w + d) + 1);
    endfunction

    function automatic int model_to(input int attempts);
        return 1 + attempts * (B_TIMEOUT + 1 + HOLDOFF);
    endfunction

    task automatic expect_run(input int n, input int ld, input logic lp, input int lr,
                              input logic lt, input logic [31:0] li, input logic [31:0] ls);
        armed = 1'b0;
        n_exp = n; lit_done = ld; lit_pass = lp; lit_retry = lr; lit_tmo = lt;
        lit_id = li; lit_ts = ls;
        fin_target = fin_count + 1;
    endtask

    task automatic launch_start();
        @(posedge clock); #2;
        start = 1'b1; t0 = edges; armed = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic go_to(input int k);
        while (edges - t0 < k) begin @(posedge clock); #2; end
    endtask

    task automatic wait_fin();
        for (int i = 0; i < 300 && fin_count < fin_target; i++) begin
            @(posedge clock); #2;
        end
        if (fin_count < fin_target) begin
            $display("FAIL scenario_end: got no completion expected end within 300 cycles");
            $fatal(1, "scenario did not complete");
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; sel = 1'b0; inject = 1'b0; inj_data = '0;
        wait_n = 0; resp_d = 1; respond = 1'b1; ts_bad = 0; base = 0;

        // Automatic check after reset release, zero-wait slave.
        @(posedge clock); #2;
        expect_run(model_ok(1, 0, 1), 6, 1'b1, 0, 1'b0, EXP_ID, EXP_TS);
        base = acc0; reset_n = 1'b1; t0 = edges; armed = 1'b1;
        wait_fin();

        // Five stall cycles on each command.
        wait_n = 5; base = acc0;
        expect_run(model_ok(1, 5, 1), 16, 1'b1, 0, 1'b0, EXP_ID, EXP_TS);
        launch_start();
        wait_fin();

        // Timestamp always off by one: every retry used, final fail.
        wait_n = 0; ts_bad = 99; base = acc0;
        expect_run(model_ok(4, 0, 1), 21, 1'b0, 3, 1'b0, EXP_ID, EXP_TS + 32'd1);
        launch_start();
        wait_fin();

        // First attempt bad, second good; start while busy and on FIN is dropped.
        ts_bad = 1; base = acc0;
        expect_run(model_ok(2, 0, 1), 11, 1'b1, 1, 1'b0, EXP_ID, EXP_TS);
        launch_start();
        go_to(4);
        start = 1'b1; @(posedge clock); #2; start = 1'b0;
        go_to(11);
        start = 1'b1; @(posedge clock); #2; start = 1'b0;
        wait_fin();

        // Reset while waiting for the timestamp, then a late response.
        ts_bad = 0; resp_d = 4; base = acc0;
        expect_run(model_ok(1, 0, 4), 12, 1'b1, 0, 1'b0, EXP_ID, EXP_TS);
        launch_start();
        go_to(8);
        armed = 1'b0; reset_n = 1'b0;
        @(posedge clock); #2;
        resp_d = 1; base = acc0;
        expect_run(model_ok(1, 0, 1), 6, 1'b1, 0, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1; inject = 1'b1; inj_data = 32'hDEAD_BEEF; t0 = edges; armed = 1'b1;
        @(posedge clock); #2;
        inject = 1'b0;
        wait_fin();

        // Silent slave on the short-timeout instance; stray response during holdoff.
        sel = 1'b1; respond = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        @(posedge clock); #2;
        expect_run(model_to(2), 55, 1'b0, 1, 1'b1, 32'd0, 32'd0);
        reset_n = 1'b1; t0 = edges; armed = 1'b1;
        go_to(15);
        inject = 1'b1; inj_data = 32'h1234_5678;
        @(posedge clock); #2;
        inject = 1'b0;
        wait_fin();

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
